// File: rtl/arc4_encrypt.sv
// arc4_encrypt: RC4 encryptor. Reads a length-prefixed plaintext from PT memory,
// runs S-box init, key schedule and keystream generation against an external
// 256x8 single-port synchronous S-box RAM, and writes the length-prefixed
// ciphertext to CT memory (byte 0 = length N, bytes 1..N = data).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   en / rdy              start request (sampled while rdy=1) / idle indicator
//   key                   RC4 key, latched when en is accepted; byte 0 is the MSB byte
//   pt_addr / pt_rddata   plaintext read port, data valid one cycle after address
//   ct_addr / ct_wrdata / ct_wren   ciphertext write port
//   s_addr / s_rddata / s_wrdata / s_wren   S-box RAM port, read data one cycle after address
//
// State     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for en, rdy=1
// INIT      | S[i] = i, one write per cycle
// KSA_RI    | KSA: issue read of S[i]
// KSA_RJ    | KSA: capture S[i], compute new j, issue read of S[j]
// KSA_WI    | KSA: capture S[j], write S[i] = old S[j]
// KSA_WJ    | KSA: write S[j] = old S[i], advance i and key byte
// RDLEN_RD  | issue read of pt[0]
// RDLEN_WR  | capture len, write ct[0] = len
// PRGA_RI   | PRGA: i = i+1, issue read of S[i]
// PRGA_RJ   | PRGA: capture S[i], j = j+S[i], issue read of S[j]
// PRGA_WI   | PRGA: capture S[j], write S[i] = old S[j]
// PRGA_WJ   | PRGA: write S[j] = old S[i]
// PRGA_RP   | PRGA: issue reads of S[S[i]+S[j]] and pt[k]
// PRGA_WC   | PRGA: write ct[k] = pt[k] ^ pad
// DONE      | job finished, rdy=1 (a new en is accepted here as well)

module arc4_encrypt #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren,
    output logic [7:0]             s_addr,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren
);

    localparam int KW = 8 * KEY_BYTES;

    typedef enum logic [3:0] {
        IDLE, INIT,
        KSA_RI, KSA_RJ, KSA_WI, KSA_WJ,
        RDLEN_RD, RDLEN_WR,
        PRGA_RI, PRGA_RJ, PRGA_WI, PRGA_WJ, PRGA_RP, PRGA_WC,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic [7:0]    i, i_nx;
    logic [7:0]    j, j_nx;
    logic [7:0]    k, k_nx;
    logic [7:0]    len, len_nx;
    logic [7:0]    si, si_nx;
    logic [7:0]    sj, sj_nx;
    // Key is rotated one byte per KSA step so the top byte is always keybyte[i mod KEY_BYTES].
    logic [KW-1:0] key_sh, key_sh_nx;
    logic [7:0]    key_byte;

    assign key_byte = key_sh[KW-1 -: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            len    <= '0;
            si     <= '0;
            sj     <= '0;
            key_sh <= '0;
        end else begin
            state  <= state_nx;
            i      <= i_nx;
            j      <= j_nx;
            k      <= k_nx;
            len    <= len_nx;
            si     <= si_nx;
            sj     <= sj_nx;
            key_sh <= key_sh_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        i_nx      = i;
        j_nx      = j;
        k_nx      = k;
        len_nx    = len;
        si_nx     = si;
        sj_nx     = sj;
        key_sh_nx = key_sh;
        rdy       = 1'b0;
        pt_addr   = '0;
        ct_addr   = '0;
        ct_wrdata = '0;
        ct_wren   = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;

        case (state)
            IDLE, DONE: begin
                rdy = 1'b1;
                if (en) begin
                    key_sh_nx = key;
                    i_nx      = '0;
                    j_nx      = '0;
                    state_nx  = INIT;
                end else if (state == DONE) begin
                    state_nx = IDLE;
                end
            end
            INIT: begin
                s_addr   = i;
                s_wrdata = i;
                s_wren   = 1'b1;
                i_nx     = i + 8'd1;
                if (i == 8'hFF) state_nx = KSA_RI;
            end
            KSA_RI: begin
                s_addr   = i;
                state_nx = KSA_RJ;
            end
            KSA_RJ: begin
                si_nx    = s_rddata;
                j_nx     = j + s_rddata + key_byte;
                s_addr   = j_nx;
                state_nx = KSA_WI;
            end
            KSA_WI: begin
                sj_nx    = s_rddata;
                s_addr   = i;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_nx = KSA_WJ;
            end
            KSA_WJ: begin
                // When i == j both writes carry the same value, so S is unchanged.
                s_addr    = j;
                s_wrdata  = si;
                s_wren    = 1'b1;
                i_nx      = i + 8'd1;
                key_sh_nx = {key_sh[KW-9:0], key_sh[KW-1 -: 8]};
                state_nx  = (i == 8'hFF) ? RDLEN_RD : KSA_RI;
            end
            RDLEN_RD: begin
                pt_addr  = 8'd0;
                state_nx = RDLEN_WR;
            end
            RDLEN_WR: begin
                len_nx    = pt_rddata;
                ct_addr   = 8'd0;
                ct_wrdata = pt_rddata;
                ct_wren   = 1'b1;
                i_nx      = '0;
                j_nx      = '0;
                k_nx      = 8'd1;
                state_nx  = (pt_rddata == 8'd0) ? DONE : PRGA_RI;
            end
            PRGA_RI: begin
                i_nx     = i + 8'd1;
                s_addr   = i_nx;
                state_nx = PRGA_RJ;
            end
            PRGA_RJ: begin
                si_nx    = s_rddata;
                j_nx     = j + s_rddata;
                s_addr   = j_nx;
                state_nx = PRGA_WI;
            end
            PRGA_WI: begin
                sj_nx    = s_rddata;
                s_addr   = i;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_nx = PRGA_WJ;
            end
            PRGA_WJ: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
                state_nx = PRGA_RP;
            end
            PRGA_RP: begin
                // Sum of the swapped pair is the same as before the swap.
                s_addr   = si + sj;
                pt_addr  = k;
                state_nx = PRGA_WC;
            end
            PRGA_WC: begin
                ct_addr   = k;
                ct_wrdata = pt_rddata ^ s_rddata;
                ct_wren   = 1'b1;
                // Stop on equality so len=255 ends at k=255 without wrapping.
                if (k == len) begin
                    state_nx = DONE;
                end else begin
                    k_nx     = k + 8'd1;
                    state_nx = PRGA_RI;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// tb_arc4_encrypt: directed bench for arc4_encrypt with behavioural PT, CT and
// S-box memories, a CT write monitor and a small software RC4 model.
module tb_arc4_encrypt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        rdy;
    logic [23:0] key = '0;
    logic [7:0]  pt_addr, pt_rddata;
    logic [7:0]  ct_addr, ct_wrdata;
    logic        ct_wren;
    logic [7:0]  s_addr, s_rddata, s_wrdata;
    logic        s_wren;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] s_mem  [256];
    logic [7:0] ks     [256];
    logic [7:0] ms     [256];

    int         wr_count = 0;
    logic [7:0] last_addr = '0;
    logic [7:0] max_addr = '0;
    bit         order_bad = 1'b0;

    arc4_encrypt #(.KEY_BYTES(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
        .pt_addr(pt_addr), .pt_rddata(pt_rddata),
        .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_wren) s_mem[s_addr] <= s_wrdata;
        s_rddata  <= s_mem[s_addr];
        pt_rddata <= pt_mem[pt_addr];
    end

    always @(posedge clk) begin
        if (rdy && en) begin
            wr_count  <= 0;
            order_bad <= 1'b0;
            max_addr  <= '0;
        end else if (ct_wren) begin
            ct_mem[ct_addr] <= ct_wrdata;
            wr_count        <= wr_count + 1;
            if (wr_count != 0 && ct_addr <= last_addr) order_bad <= 1'b1;
            last_addr <= ct_addr;
            if (ct_addr > max_addr) max_addr <= ct_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rc4_model(input logic [23:0] k_in, input int n);
        int j;
        int ii;
        logic [7:0] t;
        logic [7:0] kb;
        for (int x = 0; x < 256; x++) ms[x] = 8'(x);
        j = 0;
        for (int x = 0; x < 256; x++) begin
            kb = 8'((k_in >> (8 * (2 - (x % 3)))) & 24'hFF);
            j  = (j + int'(ms[x]) + int'(kb)) & 255;
            t = ms[x]; ms[x] = ms[j]; ms[j] = t;
        end
        ii = 0;
        j  = 0;
        for (int x = 1; x <= n; x++) begin
            ii = (ii + 1) & 255;
            j  = (j + int'(ms[ii])) & 255;
            t = ms[ii]; ms[ii] = ms[j]; ms[j] = t;
            ks[x] = ms[(int'(ms[ii]) + int'(ms[j])) & 255];
        end
    endtask

    task automatic wait_rdy(input string tag);
        int n;
        n = 0;
        while (rdy !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, rdy}, 32'd1);
    endtask

    // Starts a job; optionally pokes en with another key while busy.
    task automatic run_job(input logic [23:0] k_in, input bit poke);
        @(negedge clk);
        key = k_in;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        chk("rdy_busy", {31'd0, rdy}, 32'd0);
        if (poke) begin
            repeat (40) @(negedge clk);
            key = 24'hFFFFFF;
            en  = 1'b1;
            repeat (3) @(negedge clk);
            en  = 1'b0;
            key = 24'h000000;
        end
        wait_rdy("job_done");
    endtask

    task automatic load_text(input string s);
        pt_mem[0] = 8'(s.len());
        for (int x = 0; x < s.len(); x++) pt_mem[x + 1] = s[x];
    endtask

    logic [7:0] exp_key_ct [10];
    string      fox;

    initial begin
        int bad;
        bit seen [256];

        exp_key_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        fox = "The quick brown fox!";
        for (int x = 0; x < 256; x++) pt_mem[x] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_rdy", {31'd0, rdy}, 32'd1);
        chk("rst_ct_wren", {31'd0, ct_wren}, 32'd0);
        chk("rst_s_wren", {31'd0, s_wren}, 32'd0);
        chk("rst_addrs", {8'd0, pt_addr, ct_addr, s_addr}, 32'd0);
        chk("rst_data", {16'd0, ct_wrdata, s_wrdata}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rdy", {31'd0, rdy}, 32'd1);

        // Known-answer vector: key "Key", plaintext "Plaintext".
        load_text("Plaintext");
        run_job(24'h4B6579, 1'b0);
        for (int x = 0; x < 10; x++)
            chk($sformatf("key_ct[%0d]", x), {24'd0, ct_mem[x]}, {24'd0, exp_key_ct[x]});
        chk("key_wr_count", wr_count, 32'd10);
        chk("key_order", {31'd0, order_bad}, 32'd0);
        chk("key_max_addr", {24'd0, max_addr}, 32'd9);
        rc4_model(24'h4B6579, 9);
        bad = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== ms[x]) bad++;
        chk("key_sbox_final", bad, 32'd0);

        // len = 0: only ct[0] written, S still a permutation.
        pt_mem[0] = 8'h00;
        run_job(24'h123456, 1'b0);
        chk("len0_wr_count", wr_count, 32'd1);
        chk("len0_ct0", {24'd0, ct_mem[0]}, 32'd0);
        chk("len0_max_addr", {24'd0, max_addr}, 32'd0);
        for (int x = 0; x < 256; x++) seen[x] = 1'b0;
        for (int x = 0; x < 256; x++) seen[s_mem[x]] = 1'b1;
        bad = 0;
        for (int x = 0; x < 256; x++) if (!seen[x]) bad++;
        chk("len0_sbox_perm", bad, 32'd0);

        // Round trip with key 000018: encrypt, then decrypt the CT with the DUT.
        load_text(fox);
        run_job(24'h000018, 1'b0);
        rc4_model(24'h000018, 20);
        chk("rt_ct0", {24'd0, ct_mem[0]}, 32'd20);
        chk("rt_wr_count", wr_count, 32'd21);
        bad = 0;
        for (int x = 1; x <= 20; x++) if ((ct_mem[x] ^ ks[x]) !== pt_mem[x]) bad++;
        chk("rt_model_decrypt", bad, 32'd0);
        for (int x = 0; x <= 20; x++) pt_mem[x] = ct_mem[x];
        run_job(24'h000018, 1'b0);
        bad = 0;
        for (int x = 0; x < 20; x++) if (ct_mem[x + 1] !== fox[x]) bad++;
        chk("rt_dut_decrypt", bad, 32'd0);

        // len = 255 with zero plaintext yields raw keystream.
        pt_mem[0] = 8'hFF;
        for (int x = 1; x < 256; x++) pt_mem[x] = 8'h00;
        run_job(24'hA5C33C, 1'b0);
        rc4_model(24'hA5C33C, 255);
        bad = 0;
        for (int x = 1; x < 256; x++) if (ct_mem[x] !== ks[x]) bad++;
        chk("len255_keystream", bad, 32'd0);
        chk("len255_ct0", {24'd0, ct_mem[0]}, 32'd255);
        chk("len255_wr_count", wr_count, 32'd256);
        chk("len255_max_addr", {24'd0, max_addr}, 32'd255);
        chk("len255_order", {31'd0, order_bad}, 32'd0);

        // en poked with another key while busy must be ignored.
        load_text("Plaintext");
        run_job(24'h4B6579, 1'b1);
        for (int x = 0; x < 10; x++)
            chk($sformatf("poke_ct[%0d]", x), {24'd0, ct_mem[x]}, {24'd0, exp_key_ct[x]});
        chk("poke_wr_count", wr_count, 32'd10);
        repeat (2) @(negedge clk);
        chk("poke_idle", {31'd0, rdy}, 32'd1);

        // Asynchronous reset in the middle of KSA, then a clean job.
        @(negedge clk);
        key = 24'h010203;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        repeat (400) @(negedge clk);
        begin
            int n;
            n = 0;
            while (s_wren !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        chk("ksa_write_seen", {31'd0, s_wren}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rdy", {31'd0, rdy}, 32'd1);
        chk("arst_s_wren", {31'd0, s_wren}, 32'd0);
        chk("arst_ct_wren", {31'd0, ct_wren}, 32'd0);
        chk("arst_s_addr", {24'd0, s_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load_text(fox);
        run_job(24'h000018, 1'b0);
        rc4_model(24'h000018, 20);
        bad = 0;
        for (int x = 1; x <= 20; x++) if (ct_mem[x] !== (pt_mem[x] ^ ks[x])) bad++;
        chk("after_rst_ct", bad, 32'd0);
        chk("after_rst_wr_count", wr_count, 32'd21);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
